// File: rtl/g_arb_pkg.sv
// Shared types and sizing for the 4-way round-robin arbiter.
// Single source for state encoding, requester count and pointer width.
package g_arb_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/g_rr_pick.sv
// Round-robin picker: first set request scanning ptr, ptr+1, ... mod N_REQ.
// Purely combinational, zero latency, no flow control.
module g_rr_pick
  import g_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [PTR_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [PTR_W-1:0] idx;

  // Scan from the far end so the closest candidate to ptr is the last write.
  always_comb begin
    idx      = '0;
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        pick_idx = idx;
        pick_vld = 1'b1;
      end
    end
    if (pick_vld) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/g_4arb_rr.sv
// 4-way round-robin arbiter, registered grant one cycle after request, hold-limit preemption.
// No backpressure; G_4ARB_LOCK_EN adds a LOCK input that suppresses preemption.
module g_4arb_rr
  import g_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             CLK,
  input  logic             CD,
`ifdef G_4ARB_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [PTR_W-1:0] GID,
  output logic             BUSY
);

  localparam int              HC_W       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit              PREEMPT_EN = (HOLD_MAX > 0);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  arb_state_t       state_q, state_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [PTR_W-1:0] gid_q, gid_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic [HC_W-1:0]  hold_q, hold_n;

  logic             lock;
  logic [PTR_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic             others_req;
  logic             preempt;
  logic             handoff;

`ifdef G_4ARB_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  // Release and preemption both restart the scan just past the owner.
  assign pick_ptr   = (state_q == GRANT) ? PTR_W'(gid_q + 2'd1) : ptr_q;
  assign owner_req  = |(REQ & gnt_q);
  assign others_req = |(REQ & ~gnt_q);
  assign preempt    = PREEMPT_EN && !lock && (hold_q == HOLD_LAST) && others_req;
  assign handoff    = !owner_req || preempt;

  g_rr_pick u_pick (
    .req      (REQ),
    .ptr      (pick_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      gid_q   <= gid_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    gid_n   = gid_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_n = GRANT;
          gnt_n   = pick_oh;
          gid_n   = pick_idx;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (handoff) begin
          ptr_n  = pick_ptr;
          hold_n = '0;
          if (pick_vld) begin
            gnt_n = pick_oh;
            gid_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            gid_n   = '0;
          end
        end else if (PREEMPT_EN && hold_q != HOLD_LAST) begin
          hold_n = hold_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        gid_n   = '0;
      end
    endcase
  end

  always_comb begin
    GNT  = gnt_q;
    GID  = gid_q;
    BUSY = (state_q == GRANT);
  end

endmodule

// File: tb/tb_g_4arb_rr.sv
// Randomized and directed stimulus for g_4arb_rr checked against a cycle-level ownership model.
// Define G_4ARB_LOCK_EN on both bench and RTL to exercise the LOCK input.
module tb_g_4arb_rr;

  localparam int HOLD = 8;

  logic       CLK = 1'b0;
  logic       CD  = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic [1:0] GID;
  logic       BUSY;
`ifdef G_4ARB_LOCK_EN
  logic       LOCK = 1'b0;
`endif
  logic       tb_lock = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: owner index (-1 = nobody), scan start, cycles owned so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  g_4arb_rr #(.HOLD_MAX(HOLD)) dut (
    .CLK  (CLK),
    .CD   (CD),
`ifdef G_4ARB_LOCK_EN
    .LOCK (LOCK),
`endif
    .REQ  (REQ),
    .GNT  (GNT),
    .GID  (GID),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic lk);
    logic [3:0] others;
    if (m_owner < 0) begin
      m_owner = first_from(r, m_ptr);
      m_held  = 1;
      return;
    end
    others = r;
    others[m_owner] = 1'b0;
    if (!r[m_owner] || (HOLD > 0 && !lk && m_held >= HOLD && others != 4'b0)) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = first_from(r, m_ptr);
      m_held  = 1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    chk({tag, ".gnt"},  32'(GNT),  32'(eg));
    chk({tag, ".gid"},  32'(GID),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".busy"}, 32'(BUSY), (m_owner < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    @(negedge CLK);
    REQ = r;
`ifdef G_4ARB_LOCK_EN
    LOCK = tb_lock;
`endif
    @(posedge CLK);
    model_edge(r, tb_lock);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CD  = 1'b1;
    REQ = 4'b0000;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge CLK);
    CD = 1'b0;
  endtask

  initial begin
    logic [3:0] cur;

    // Reset state, then the first grant one edge after the request.
    #1;
    check_outputs("por");
    do_reset();
    step(4'b0010, "first");
    chk("first.gnt_k", 32'(GNT), 32'h2);
    chk("first.gid_k", 32'(GID), 32'd1);

    // Owner 1 releases while 0 and 3 wait: scan resumes at 2, so 3 wins.
    step(4'b1011, "hold1");
    step(4'b1011, "hold1");
    step(4'b1001, "rel1");
    chk("rel1.gnt_k", 32'(GNT), 32'h8);
    chk("rel1.gid_k", 32'(GID), 32'd3);

    // Everyone requesting: ownership rotates every HOLD cycles.
    do_reset();
    for (int i = 0; i < 5 * HOLD + 2; i++) step(4'b1111, "rot");

    // Lone owner saturates, then a newcomer preempts on the next edge.
    do_reset();
    for (int i = 0; i < 20; i++) step(4'b0100, "solo");
    step(4'b0101, "late");
    chk("late.gnt_k", 32'(GNT), 32'h1);

    // Asynchronous clear mid-grant, with no clock edge in between.
    step(4'b0101, "pre_cd");
    #2;
    CD = 1'b1;
    #1;
    chk("cd_async.gnt",  32'(GNT),  32'h0);
    chk("cd_async.busy", 32'(BUSY), 32'h0);
    model_reset();
    @(negedge CLK);
    CD = 1'b0;
    step(4'b1111, "post_cd");
    chk("post_cd.gnt_k", 32'(GNT), 32'h1);

`ifdef G_4ARB_LOCK_EN
    do_reset();
    tb_lock = 1'b1;
    for (int i = 0; i < 30; i++) step(4'b1111, "lock");
    chk("lock.gnt_k", 32'(GNT), 32'h1);
    tb_lock = 1'b0;
    step(4'b1111, "unlock");
    chk("unlock.gnt_k", 32'(GNT), 32'h2);
`endif

    // Random sticky requests so owners often run into the hold limit.
    do_reset();
    cur = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end
`ifdef G_4ARB_LOCK_EN
      if ($urandom_range(0, 19) == 0) tb_lock = ~tb_lock;
`endif
      cur = cur ^ 4'($urandom & $urandom);
      step(cur, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
